pipe_stage_elastic: RTL and testbench
=====================================

Name: pipe_stage_elastic

Overview:
Generic, parametrised pipeline stage register with a valid/ready handshake, a one-entry skid buffer and synchronous flush. It replaces hard-wired per-field stage registers such as IF/ID and ID/EX: each stage boundary instantiates it once over a packed field bundle. Stalls propagate upstream one register at a time, without a combinational ready path. Sits between any two pipeline stages of the datapath; hazard and branch logic drive its flush.

Parameters:
DW, 32, width of the packed data bundle in bits.
RESET_VAL, 0, value loaded into main and skid data registers on reset and flush (DW bits; encodes a NOP/bubble bundle).
CNT_W, 16, width of performance counters (only used with the optional feature).

Ports:
CLK  in  1  clock, rising edge.
nRST  in  1  reset; asynchronous, active-low.
flush  in  1  synchronous kill of all held entries.
in_valid  in  1  upstream presents in_data.
in_ready  out  1  stage can accept; registered (driven from state only).
in_data  in  DW  upstream bundle.
out_valid  out  1  out_data holds a live entry.
out_ready  in  1  downstream accepts this cycle.
out_data  out  DW  bundle from main register.
occupancy  out  2  entries held: 0, 1 or 2.

Behaviour:
- push = in_valid & in_ready; pop = out_valid & out_ready; evaluated at CLK rise.
- States:
  - EMPTY: occupancy 0, out_valid 0, in_ready 1.
  - ONE: main valid, in_ready 1.
  - TWO: main and skid valid, in_ready 0.
- Transitions when flush = 0:
  - EMPTY: push -> ONE, main <= in_data; otherwise hold.
  - ONE: push & pop -> ONE, main <= in_data.
  - ONE: push & !pop -> TWO, skid <= in_data.
  - ONE: !push & pop -> EMPTY, main <= RESET_VAL.
  - ONE: otherwise hold.
  - TWO: pop -> ONE, main <= skid, skid <= RESET_VAL. push is impossible in TWO.
- flush = 1 has top priority. Next state is EMPTY, main <= RESET_VAL and skid <= RESET_VAL, regardless of push/pop. An input pushed in the flush cycle counts as consumed upstream and is discarded. A pop in the flush cycle completes normally downstream.
- Latency: accepted input appears on out_data/out_valid the next cycle when entering from EMPTY or ONE. Throughput is 1 per cycle with out_ready held at 1.
- Stability: while out_valid & !out_ready & !flush, out_data and out_valid are unchanged cycle to cycle.
- Ordering: strict FIFO; skid data is never presented before main.
- in_ready depends only on state, never on out_ready in the same cycle.
- out_data = main register; equals RESET_VAL whenever out_valid = 0.
- Reset (nRST low, any time, including mid-transfer):
  - Immediately: state EMPTY, out_valid 0, in_ready 1, occupancy 0, out_data = RESET_VAL, skid = RESET_VAL, counters 0.
  - Nothing is accepted until the first rising edge after nRST deasserts.

Optional Feature:
PIPE_STAGE_PERF_EN
- Defined: adds outputs stall_cnt (CNT_W) and bubble_cnt (CNT_W), and input perf_clr (1).
  - stall_cnt increments on each cycle with out_valid & !out_ready.
  - bubble_cnt increments on each cycle with !out_valid & out_ready.
  - Both saturate at all-ones, are cleared by reset or perf_clr, and are unaffected by flush.
  - perf_clr has priority over increment.
- Undefined: these ports and counters do not exist; block behaviour is otherwise identical.

Test Plan:
1. Reset, then in_valid=1 with data 0xA, 0xB, 0xC on consecutive cycles, out_ready=1 -> out_data 0xA, 0xB, 0xC one cycle later each, occupancy stays 1, in_ready stays 1.
2. Hold out_ready=0, push 0x11 then 0x22 -> occupancy 2, in_ready=0, out_data stays 0x11. Raise out_ready -> 0x11 then 0x22 pop in order, in_ready back to 1 one cycle after first pop.
3. In state TWO, assert flush with in_valid=1 and data 0x33 -> next cycle occupancy 0, out_valid 0, out_data=RESET_VAL, and 0x33 never appears.
4. In state ONE, deassert nRST between clock edges -> out_valid=0 and out_data=RESET_VAL immediately. After release, push 0x44 -> appears after 1 cycle.
5. DW=8, RESET_VAL=0xFF: reset -> out_data=0xFF. Push 0x00 then pop -> out_data returns to 0xFF with out_valid 0.
6. With PIPE_STAGE_PERF_EN, CNT_W=4, 20 cycles of out_valid & !out_ready -> stall_cnt=15 (saturated). Pulse perf_clr -> 0.

Source files
------------

// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic: generic pipeline stage register with a valid/ready
// handshake, a one-entry skid buffer and a synchronous flush.
//
// Handshake: a beat moves on a rising CLK edge when valid and ready are both
// high on that side. push = in_valid & in_ready, pop = out_valid & out_ready.
// in_ready is derived from the held state only, so a downstream stall reaches
// the upstream stage one register later and never through a combinational path.
//
// Optional feature macro: PIPE_STAGE_PERF_EN adds perf_clr, stall_cnt and
// bubble_cnt (saturating CNT_W-bit counters).
module pipe_stage_elastic #(
  parameter int unsigned     DW        = 32,
  parameter logic [DW-1:0]   RESET_VAL = '0,
  parameter int unsigned     CNT_W     = 16
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [1:0]    occupancy,
  output logic [1:0]    dbg_state
`ifdef PIPE_STAGE_PERF_EN
  ,
  input  logic             perf_clr,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] main_q, main_d;
  logic [DW-1:0] skid_q, skid_d;
  logic          push, pop;

  // Output decode: everything visible downstream/upstream comes from registers.
  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    occupancy = 2'd0;
    case (state_q)
      ST_EMPTY: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        occupancy = 2'd0;
      end
      ST_ONE: begin
        in_ready  = 1'b1;
        out_valid = 1'b1;
        occupancy = 2'd1;
      end
      ST_TWO: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
        occupancy = 2'd2;
      end
      default: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        occupancy = 2'd0;
      end
    endcase
  end

  assign out_data  = main_q;
  assign dbg_state = state_q;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Next-state and data-path selection; flush overrides every other move.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = RESET_VAL;
      skid_d  = RESET_VAL;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push) begin
            state_d = ST_ONE;
            main_d  = in_data;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            main_d = in_data;
          end else if (push) begin
            state_d = ST_TWO;
            skid_d  = in_data;
          end else if (pop) begin
            state_d = ST_EMPTY;
            main_d  = RESET_VAL;
          end
        end
        ST_TWO: begin
          // in_ready is low here, so only a pop can move the stage.
          if (pop) begin
            state_d = ST_ONE;
            main_d  = skid_q;
            skid_d  = RESET_VAL;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = RESET_VAL;
          skid_d  = RESET_VAL;
        end
      endcase
    end
  end

  // State and data registers; reset returns to an empty stage holding bubbles.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= ST_EMPTY;
      main_q  <= RESET_VAL;
      skid_q  <= RESET_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] bubble_q, bubble_d;

  // Saturating counters for downstream stalls and empty-stage bubbles.
  always_comb begin
    stall_d  = stall_q;
    bubble_d = bubble_q;
    if (perf_clr) begin
      stall_d  = '0;
      bubble_d = '0;
    end else begin
      if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
        stall_d = stall_q + CNT_W'(1);
      end
      if (!out_valid && out_ready && (bubble_q != {CNT_W{1'b1}})) begin
        bubble_d = bubble_q + CNT_W'(1);
      end
    end
  end

  // Counter registers; flush deliberately does not touch them.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      stall_q  <= stall_d;
      bubble_q <= bubble_d;
    end
  end

  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;
`else
  // Counters are absent in this build; CNT_W only has to be a sane width.
  if (CNT_W == 0) begin : g_cnt_w_zero
  end
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Testbench for pipe_stage_elastic: directed scenarios plus randomized traffic
// compared against a two-entry FIFO reference model kept as a queue.
module tb_pipe_stage_elastic;

  localparam int unsigned DW        = 32;
  localparam logic [31:0] RV        = 32'h0;
  localparam int unsigned CNT_W     = 4;
  localparam int          CNT_MAX   = (1 << CNT_W) - 1;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic          nRST;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
  logic [1:0]    dbg_state;
`ifdef PIPE_STAGE_PERF_EN
  logic             perf_clr;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] bubble_cnt;
`endif

  pipe_stage_elastic #(.DW(DW), .RESET_VAL(RV), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .nRST(nRST), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .dbg_state(dbg_state)
`ifdef PIPE_STAGE_PERF_EN
    , .perf_clr(perf_clr), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  // Narrow instance with a non-zero bubble value.
  logic       s_nrst, s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [7:0] s_in_data, s_out_data;
  logic [1:0] s_occupancy, s_dbg_state;
`ifdef PIPE_STAGE_PERF_EN
  logic       s_perf_clr;
  logic [3:0] s_stall_cnt, s_bubble_cnt;
`endif

  pipe_stage_elastic #(.DW(8), .RESET_VAL(8'hFF), .CNT_W(4)) dut8 (
    .CLK(CLK), .nRST(s_nrst), .flush(s_flush),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .occupancy(s_occupancy), .dbg_state(s_dbg_state)
`ifdef PIPE_STAGE_PERF_EN
    , .perf_clr(s_perf_clr), .stall_cnt(s_stall_cnt), .bubble_cnt(s_bubble_cnt)
`endif
  );

  // ---------------- reference model ----------------
  logic [DW-1:0] exp_q[$];
  int            exp_stall;
  int            exp_bubble;
  int            n_checks = 0;
  int            n_pass   = 0;

  // Expected {out_valid, in_ready, occupancy, out_data} from the model queue.
  function automatic logic [DW+3:0] model_status();
    logic [DW-1:0] d;
    d = (exp_q.size() != 0) ? exp_q[0] : RV;
    return {exp_q.size() != 0, exp_q.size() < 2, 2'(exp_q.size()), d};
  endfunction

  function automatic logic [DW+3:0] dut_status();
    return {out_valid, in_ready, occupancy, out_data};
  endfunction

  // Advance one clock: apply FIFO rules of the stage to the model, then
  // move #1 past the edge where outputs are sampled and inputs re-driven.
  task automatic cycle();
    bit push, pop, vld;
    vld  = exp_q.size() != 0;
    push = in_valid && (exp_q.size() < 2);
    pop  = vld && out_ready;
    @(posedge CLK);
    if (!nRST) begin
      exp_q.delete();
      exp_stall  = 0;
      exp_bubble = 0;
    end else begin
      if (pop)   void'(exp_q.pop_front());
      if (push)  exp_q.push_back(in_data);
      if (flush) exp_q.delete();
`ifdef PIPE_STAGE_PERF_EN
      if (perf_clr) begin
        exp_stall  = 0;
        exp_bubble = 0;
      end else begin
        if (vld && !out_ready && exp_stall < CNT_MAX)   exp_stall++;
        if (!vld && out_ready && exp_bubble < CNT_MAX) exp_bubble++;
      end
`endif
    end
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    nRST = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
`ifdef PIPE_STAGE_PERF_EN
    perf_clr = 1'b0;
`endif
    repeat (3) cycle();
    n_checks++;
    if (dut_status() !== {1'b0, 1'b1, 2'd0, RV})
      $display("FAIL reset_status: got %h required %h", dut_status(), {1'b0, 1'b1, 2'd0, RV});
    else n_pass++;
`ifdef PIPE_STAGE_PERF_EN
    n_checks++;
    if ({stall_cnt, bubble_cnt} !== '0)
      $display("FAIL reset_counters: got %h/%h required 0/0", stall_cnt, bubble_cnt);
    else n_pass++;
`endif
    nRST = 1'b1;
  endtask

  task automatic test_stream();
    logic [DW-1:0] vals [3];
    vals[0] = 32'hA; vals[1] = 32'hB; vals[2] = 32'hC;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = vals[i];
      cycle();
      n_checks++;
      if (dut_status() !== {1'b1, 1'b1, 2'd1, vals[i]})
        $display("FAIL stream_%0d: got %h required %h", i, dut_status(), {1'b1, 1'b1, 2'd1, vals[i]});
      else n_pass++;
    end
    in_valid = 1'b0;
    cycle();
    n_checks++;
    if (dut_status() !== model_status())
      $display("FAIL stream_drain: got %h required %h", dut_status(), model_status());
    else n_pass++;
  endtask

  task automatic test_skid();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h11; cycle();
    in_data = 32'h22; cycle();
    in_valid = 1'b0;
    n_checks++;
    if (dut_status() !== {1'b1, 1'b0, 2'd2, 32'h11})
      $display("FAIL skid_full: got %h required %h", dut_status(), {1'b1, 1'b0, 2'd2, 32'h11});
    else n_pass++;
    cycle();
    n_checks++;
    if (dut_status() !== {1'b1, 1'b0, 2'd2, 32'h11})
      $display("FAIL skid_hold: got %h required %h", dut_status(), {1'b1, 1'b0, 2'd2, 32'h11});
    else n_pass++;
    out_ready = 1'b1;
    cycle();
    n_checks++;
    if (dut_status() !== {1'b1, 1'b1, 2'd1, 32'h22})
      $display("FAIL skid_pop1: got %h required %h", dut_status(), {1'b1, 1'b1, 2'd1, 32'h22});
    else n_pass++;
    cycle();
    n_checks++;
    if (dut_status() !== {1'b0, 1'b1, 2'd0, RV})
      $display("FAIL skid_pop2: got %h required %h", dut_status(), {1'b0, 1'b1, 2'd0, RV});
    else n_pass++;
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h1; cycle();
    in_data = 32'h2; cycle();
    flush = 1'b1; in_data = 32'h33; cycle();
    flush = 1'b0; in_valid = 1'b0;
    n_checks++;
    if (dut_status() !== {1'b0, 1'b1, 2'd0, RV})
      $display("FAIL flush_empty: got %h required %h", dut_status(), {1'b0, 1'b1, 2'd0, RV});
    else n_pass++;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_checks++;
      if (out_valid !== 1'b0 || out_data === 32'h33)
        $display("FAIL flush_idle_%0d: got valid=%b data=%h required valid=0 data=%h", i, out_valid, out_data, RV);
      else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h55; cycle();
    in_valid = 1'b0;
    #3 nRST = 1'b0;
    #1;
    exp_q.delete(); exp_stall = 0; exp_bubble = 0;
    n_checks++;
    if (dut_status() !== {1'b0, 1'b1, 2'd0, RV})
      $display("FAIL async_reset: got %h required %h", dut_status(), {1'b0, 1'b1, 2'd0, RV});
    else n_pass++;
    #2 nRST = 1'b1;
    in_valid = 1'b1; in_data = 32'h44;
    cycle();
    in_valid = 1'b0;
    n_checks++;
    if (dut_status() !== {1'b1, 1'b1, 2'd1, 32'h44})
      $display("FAIL after_reset_push: got %h required %h", dut_status(), {1'b1, 1'b1, 2'd1, 32'h44});
    else n_pass++;
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      in_data   = $urandom;
      cycle();
      n_checks++;
      if (dut_status() !== model_status()) begin
        errs++;
        if (errs <= 10)
          $display("FAIL random_%0d: got %h required %h", i, dut_status(), model_status());
      end else n_pass++;
    end
    flush = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_small_width();
    s_flush = 1'b0; s_in_valid = 1'b0; s_in_data = 8'h5A; s_out_ready = 1'b0;
    s_nrst = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    n_checks++;
    if ({s_out_valid, s_occupancy, s_out_data} !== {1'b0, 2'd0, 8'hFF})
      $display("FAIL w8_reset: got %h required %h", {s_out_valid, s_occupancy, s_out_data}, {1'b0, 2'd0, 8'hFF});
    else n_pass++;
    s_nrst = 1'b1;
    s_in_valid = 1'b1; s_in_data = 8'h00;
    @(posedge CLK); #1;
    s_in_valid = 1'b0;
    n_checks++;
    if ({s_out_valid, s_occupancy, s_out_data} !== {1'b1, 2'd1, 8'h00})
      $display("FAIL w8_push: got %h required %h", {s_out_valid, s_occupancy, s_out_data}, {1'b1, 2'd1, 8'h00});
    else n_pass++;
    s_out_ready = 1'b1;
    @(posedge CLK); #1;
    n_checks++;
    if ({s_out_valid, s_occupancy, s_out_data} !== {1'b0, 2'd0, 8'hFF})
      $display("FAIL w8_pop: got %h required %h", {s_out_valid, s_occupancy, s_out_data}, {1'b0, 2'd0, 8'hFF});
    else n_pass++;
  endtask

`ifdef PIPE_STAGE_PERF_EN
  task automatic test_perf();
    out_ready = 1'b0; in_valid = 1'b0;
    flush = 1'b1; cycle();
    flush = 1'b0; perf_clr = 1'b1; cycle();
    perf_clr = 1'b0;
    in_valid = 1'b1; in_data = 32'h77; cycle();
    in_valid = 1'b0;
    repeat (20) cycle();
    n_checks++;
    if (stall_cnt !== 4'd15)
      $display("FAIL stall_sat: got %0d required 15", stall_cnt);
    else n_pass++;
    flush = 1'b1; cycle();
    flush = 1'b0;
    n_checks++;
    if (stall_cnt !== CNT_W'(exp_stall))
      $display("FAIL stall_flush: got %0d required %0d", stall_cnt, exp_stall);
    else n_pass++;
    in_valid = 1'b1; in_data = 32'h78; cycle();
    in_valid = 1'b0; perf_clr = 1'b1; cycle();
    perf_clr = 1'b0;
    n_checks++;
    if (stall_cnt !== 4'd0 || bubble_cnt !== 4'd0)
      $display("FAIL perf_clr: got %0d/%0d required 0/0", stall_cnt, bubble_cnt);
    else n_pass++;
    out_ready = 1'b1;
    repeat (4) cycle();
    n_checks++;
    if (bubble_cnt !== CNT_W'(exp_bubble) || stall_cnt !== CNT_W'(exp_stall))
      $display("FAIL bubble_cnt: got %0d/%0d required %0d/%0d", bubble_cnt, stall_cnt, exp_bubble, exp_stall);
    else n_pass++;
  endtask
`endif

  initial begin
    s_nrst = 1'b0; s_flush = 1'b0; s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b0;
`ifdef PIPE_STAGE_PERF_EN
    s_perf_clr = 1'b0;
`endif
    exp_stall = 0; exp_bubble = 0;
    test_reset();
    test_stream();
    test_skid();
    test_flush();
    test_async_reset();
    test_random();
    test_small_width();
`ifdef PIPE_STAGE_PERF_EN
    test_perf();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: got no completion required completion by 200000");
    $fatal(1, "timeout");
  end

endmodule
